// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, compare encodings.
// Build option: SEQ_ALU_DIV_EN enables the iterative divider for opcode 7.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;

  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Signed three-way compare folded into the compareVal encoding.
  function automatic logic [1:0] cmp_enc(input logic gt, input logic eq);
    if (eq)      return CMP_EQ;
    else if (gt) return CMP_GT;
    else         return CMP_LT;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: radix-2 shift-add multiply and (with SEQ_ALU_DIV_EN) restoring
// divide, both unsigned, W iterations counted down from W to the terminal count.
// i_start loads operands straight from the issue port; o_done pulses for one cycle
// after the last iteration, with o_lo/o_hi holding the result.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
`ifdef SEQ_ALU_DIV_EN
  input  logic         i_div,
`endif
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_opnd;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_nxt_lo;
  logic [W-1:0]  w_nxt_hi;

`ifdef SEQ_ALU_DIV_EN
  logic          r_div;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;

  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};
`endif

  assign w_sum = {1'b0, r_hi} + {1'b0, r_opnd};

  // One iteration step: multiply shifts the {hi,lo} product right, divide shifts left.
  always_comb begin
    if (r_lo[0]) {w_nxt_hi, w_nxt_lo} = {w_sum, r_lo[W-1:1]};
    else         {w_nxt_hi, w_nxt_lo} = {1'b0, r_hi, r_lo[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      if (!w_diff[W]) begin
        w_nxt_hi = w_diff[W-1:0];
        w_nxt_lo = {r_lo[W-2:0], 1'b1};
      end else begin
        w_nxt_hi = w_shift[W-1:0];
        w_nxt_lo = {r_lo[W-2:0], 1'b0};
      end
    end
`endif
  end

  // Operand load on start, then W iterations with a down-counter to the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_div  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(W);
        r_hi   <= '0;
`ifdef SEQ_ALU_DIV_EN
        r_div  <= i_div;
        r_lo   <= i_div ? i_a : i_b;
        r_opnd <= i_div ? i_b : i_a;
`else
        r_lo   <= i_b;
        r_opnd <= i_a;
`endif
      end else if (r_busy) begin
        r_cnt <= r_cnt - CW'(1);
        r_hi  <= w_nxt_hi;
        r_lo  <= w_nxt_lo;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: one registered operation per transaction.
// Build option: SEQ_ALU_DIV_EN enables iterative divide; otherwise opcode 7 is illegal.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// EXEC  | single-cycle op (ADD..SUB, illegal, divide by zero) computed from latched operands
// MUL   | shift-add multiply iterating in seq_alu_muldiv
// DIV   | restoring divide iterating in seq_alu_muldiv
// DONE  | out_valid high, result held until out_ready
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic [W-1:0] r_hi,
  output logic         cout,
  output logic         zero,
  output logic         error,
  output logic [1:0]   compareVal
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [3:0]   r_op;
  logic [W-1:0] r_res;
  logic [W-1:0] r_res_hi;
  logic         r_cout;
  logic         r_zero;
  logic         r_err;
  logic [1:0]   r_cmp;

  logic         w_accept;
  logic         w_is_mul;
  logic         w_is_div;
  logic         w_md_start;
  logic         w_md_done;
  logic         w_load;
  logic [W-1:0] w_md_lo;
  logic [W-1:0] w_md_hi;
  logic [W:0]   w_add;
  logic [W:0]   w_sub;
  logic         w_sh_big;
  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;
  logic         w_cout;
  logic         w_err;
  logic [1:0]   w_cmp;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_is_mul = (opcode == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
  // Divide by zero takes the single-cycle path and never starts the iteration.
  assign w_is_div = (opcode == OP_DIV) && (b != '0);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_md_start = w_accept && (w_is_mul || w_is_div);

  seq_alu_muldiv #(.W(W)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_md_start),
`ifdef SEQ_ALU_DIV_EN
    .i_div   (w_is_div),
`endif
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mul)      w_next = MUL;
          else if (w_is_div) w_next = DIV;
          else               w_next = EXEC;
        end
      end
      EXEC:     w_next = DONE;
      MUL, DIV: if (w_md_done) w_next = DONE;
      DONE:     if (out_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  assign w_add    = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub    = {1'b0, r_a} - {1'b0, r_b};
  assign w_sh_big = |r_b[W-1:SHW];

  // Result and flag selection for whichever path is finishing.
  always_comb begin
    w_lo   = '0;
    w_hi   = '0;
    w_cout = 1'b0;
    w_err  = 1'b0;
    w_cmp  = CMP_EQ;
    if (r_state == MUL) begin
      w_lo   = w_md_lo;
      w_hi   = w_md_hi;
      w_cout = |w_md_hi;
    end else if (r_state == DIV) begin
      w_lo = w_md_lo;
      w_hi = w_md_hi;
    end else begin
      case (r_op)
        OP_ADD: {w_cout, w_lo} = w_add;
        OP_AND: w_lo = r_a & r_b;
        OP_OR:  w_lo = r_a | r_b;
        OP_SHL: w_lo = w_sh_big ? '0 : (r_a << r_b[SHW-1:0]);
        OP_SHR: w_lo = w_sh_big ? '0 : (r_a >> r_b[SHW-1:0]);
        OP_SUB: begin
          {w_cout, w_lo} = w_sub;
          w_cmp = cmp_enc($signed(r_a) > $signed(r_b), r_a == r_b);
        end
`ifdef SEQ_ALU_DIV_EN
        OP_DIV: begin
          w_lo  = '1;
          w_hi  = r_a;
          w_err = 1'b1;
        end
`endif
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_load = (r_state == EXEC) ||
                  (((r_state == MUL) || (r_state == DIV)) && w_md_done);

  // Operand latch at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= opcode;
    end
  end

  // Result registers; result and flags change together and only when a result lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_cmp    <= CMP_EQ;
    end else if (w_load) begin
      r_res    <= w_lo;
      r_res_hi <= w_hi;
      r_cout   <= w_cout;
      r_zero   <= (w_lo == '0);
      r_err    <= w_err;
      r_cmp    <= w_cmp;
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign r          = r_res;
  assign r_hi       = r_res_hi;
  assign cout       = r_cout;
  assign zero       = r_zero;
  assign error      = r_err;
  assign compareVal = r_cmp;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=16): vector table through a scoreboard queue,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         cout;
  logic         zero;
  logic         error;
  logic [1:0]   compareVal;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         cout;
    logic         zero;
    logic         err;
    logic [1:0]   cmp;
    int           lat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  seq_alu #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .r_hi       (r_hi),
    .cout       (cout),
    .zero       (zero),
    .error      (error),
    .compareVal (compareVal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input string nm, input logic [3:0] op,
                              input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                              input logic [W-1:0] r_i, input logic [W-1:0] rh_i,
                              input logic c_i, input logic z_i, input logic e_i,
                              input logic [1:0] cmp_i, input int lat_i);
    vec_t v;
    v.name = nm; v.op = op; v.a = a_i; v.b = b_i; v.r = r_i; v.rh = rh_i;
    v.cout = c_i; v.zero = z_i; v.err = e_i; v.cmp = cmp_i; v.lat = lat_i;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    @(negedge clk);
    in_valid = 1'b1; opcode = v.op; a = v.a; b = v.b;
    exp_q.push_back(v);
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); opcode = 4'($urandom);
    @(negedge clk);
    chk({v.name, " busy_in_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat = i;
      if (out_valid) break;
    end
    chk({v.name, " latency"}, lat, v.lat);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, " r"},          32'(r),          32'(e.r));
      chk({e.name, " r_hi"},       32'(r_hi),       32'(e.rh));
      chk({e.name, " cout"},       32'(cout),       32'(e.cout));
      chk({e.name, " zero"},       32'(zero),       32'(e.zero));
      chk({e.name, " error"},      32'(error),      32'(e.err));
      chk({e.name, " compareVal"}, 32'(compareVal), 32'(e.cmp));
    end
    @(negedge clk);
    chk({v.name, " out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({v.name, " in_ready_rise"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    tbl.push_back(mk("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0, CMP_EQ, 1));
    tbl.push_back(mk("add",       OP_ADD, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("and",       OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("or",        OP_OR,  16'hF0F0, 16'h0F01, 16'hFFF1, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("shl",       OP_SHL, 16'h0004, 16'h0001, 16'h0008, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("shl_15",    OP_SHL, 16'h0003, 16'h000F, 16'h8000, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("shl_big",   OP_SHL, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 0, 1, 0, CMP_EQ, 1));
    tbl.push_back(mk("shr",       OP_SHR, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 0, 0, 0, CMP_EQ, 1));
    tbl.push_back(mk("shr_big",   OP_SHR, 16'h8000, 16'h0104, 16'h0000, 16'h0000, 0, 1, 0, CMP_EQ, 1));
    tbl.push_back(mk("sub_lt",    OP_SUB, 16'h0001, 16'h0003, 16'hFFFE, 16'h0000, 1, 0, 0, CMP_LT, 1));
    tbl.push_back(mk("sub_eq",    OP_SUB, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 0, 1, 0, CMP_EQ, 1));
    tbl.push_back(mk("sub_gt_s",  OP_SUB, 16'h0005, 16'hFFFF, 16'h0006, 16'h0000, 1, 0, 0, CMP_GT, 1));
    tbl.push_back(mk("sub_lt_s",  OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 0, 0, CMP_LT, 1));
    tbl.push_back(mk("mul_hi",    OP_MUL, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1, 1, 0, CMP_EQ, 17));
    tbl.push_back(mk("mul_max",   OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 0, CMP_EQ, 17));
    tbl.push_back(mk("mul_small", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 0, 0, 0, CMP_EQ, 17));
    tbl.push_back(mk("ill_9",     4'd9,   16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 1, 1, CMP_EQ, 1));
    tbl.push_back(mk("ill_15",    4'd15,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1, CMP_EQ, 1));
`ifdef SEQ_ALU_DIV_EN
    tbl.push_back(mk("div",       OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    0, 0, 0, CMP_EQ, 17));
    tbl.push_back(mk("div_zero",  OP_DIV, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 0, 0, 1, CMP_EQ, 1));
    tbl.push_back(mk("div_max",   OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, CMP_EQ, 17));
    tbl.push_back(mk("div_small", OP_DIV, 16'h0003, 16'h0009, 16'h0000, 16'h0003, 0, 1, 0, CMP_EQ, 17));
`else
    tbl.push_back(mk("div_off",   OP_DIV, 16'd100,  16'd7,    16'h0000, 16'h0000, 0, 1, 1, CMP_EQ, 1));
    tbl.push_back(mk("div_off_0", OP_DIV, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, CMP_EQ, 1));
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready",   32'(in_ready),   32'd1);
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst r",          32'(r),          32'd0);
    chk("rst r_hi",       32'(r_hi),       32'd0);
    chk("rst flags",      32'({cout, zero, error}), 32'd0);
    chk("rst compareVal", 32'(compareVal), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Backpressure: SHL result held while out_ready is low and a new request waits.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; opcode = OP_SHL; a = 16'h0004; b = 16'h0001;
    @(posedge clk);
    #1;
    opcode = OP_ADD; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp r held",    32'(r),         32'h8);
      chk("bp in_ready",  32'(in_ready),  32'd0);
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    a = 16'h0001; b = 16'h0001; out_ready = 1'b1;
    @(negedge clk);
    chk("bp exit out_valid", 32'(out_valid), 32'd0);
    chk("bp exit in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp next exec", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("bp next out_valid", 32'(out_valid), 32'd1);
    chk("bp next r",         32'(r),         32'h2);
    chk("bp next zero",      32'(zero),      32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp no queued op", 32'(out_valid), 32'd0);
    end

    // Reset five cycles into a multiply discards it and clears every output.
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_MUL; a = 16'h0003; b = 16'h0005;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mrst out_valid",  32'(out_valid),  32'd0);
    chk("mrst in_ready",   32'(in_ready),   32'd1);
    chk("mrst r",          32'(r),          32'd0);
    chk("mrst r_hi",       32'(r_hi),       32'd0);
    chk("mrst flags",      32'({cout, zero, error}), 32'd0);
    chk("mrst compareVal", 32'(compareVal), 32'd0);
    reset = 1'b0;
    run_vec(mk("mul_after_rst", OP_MUL, 16'd7, 16'd9, 16'd63, 16'd0, 0, 0, 0, CMP_EQ, 17));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post rst idle", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
